// File: rtl/param_lock.sv
// Code lock with programmable code, timed open window and attempt limiting.
// Define PARAM_LOCK_LOCKOUT_EN to enable the timed lockout after MAX_TRIES wrong codes.
module param_lock #(
    parameter int WIDTH       = 16,
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               in,
    input  logic                           in_valid,
    input  logic                           prog,
    output logic                           ready,
    output logic                           out,
    output logic                           match,
    output logic                           fail,
    output logic                           alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int OW = $clog2(OPEN_CYCLES + 1);
    localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);
    localparam logic [OW-1:0] OPEN_INIT  = OW'(OPEN_CYCLES);

    typedef enum logic [1:0] {
        S_UNSET,
        S_LOCKED,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] code;
    logic [OW-1:0]    open_cnt;
    logic             take;

`ifdef PARAM_LOCK_LOCKOUT_EN
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_INIT = LW'(LOCK_CYCLES);
    logic [LW-1:0] lock_cnt;
`endif

    // ready is registered, so a word offered during lockout is never taken
    assign take = in_valid && ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_UNSET;
            code       <= '0;
            open_cnt   <= '0;
            out        <= 1'b1;
            ready      <= 1'b1;
            match      <= 1'b0;
            fail       <= 1'b0;
            alarm      <= 1'b0;
            tries_left <= TRIES_INIT;
`ifdef PARAM_LOCK_LOCKOUT_EN
            lock_cnt   <= '0;
`endif
        end else begin
            match <= 1'b0;
            fail  <= 1'b0;
            case (state)
                S_UNSET: begin
                    if (take && prog) begin
                        code  <= in;
                        state <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (take && !prog) begin
                        if (in == code) begin
                            match      <= 1'b1;
                            out        <= 1'b0;
                            tries_left <= TRIES_INIT;
                            open_cnt   <= OPEN_INIT;
                            state      <= S_OPEN;
                        end else begin
                            fail <= 1'b1;
`ifdef PARAM_LOCK_LOCKOUT_EN
                            if (tries_left <= TW'(1)) begin
                                tries_left <= '0;
                                lock_cnt   <= LOCK_INIT;
                                alarm      <= 1'b1;
                                ready      <= 1'b0;
                                state      <= S_LOCKOUT;
                            end else begin
                                tries_left <= tries_left - TW'(1);
                            end
`endif
                        end
                    end
                end
                S_OPEN: begin
                    if (take && prog) begin
                        code     <= in;
                        out      <= 1'b1;
                        open_cnt <= '0;
                        state    <= S_LOCKED;
                    end else if (open_cnt <= OW'(1)) begin
                        out      <= 1'b1;
                        open_cnt <= '0;
                        state    <= S_LOCKED;
                    end else begin
                        open_cnt <= open_cnt - OW'(1);
                    end
                end
`ifdef PARAM_LOCK_LOCKOUT_EN
                S_LOCKOUT: begin
                    if (lock_cnt <= LW'(1)) begin
                        lock_cnt   <= '0;
                        alarm      <= 1'b0;
                        ready      <= 1'b1;
                        tries_left <= TRIES_INIT;
                        state      <= S_LOCKED;
                    end else begin
                        lock_cnt <= lock_cnt - LW'(1);
                    end
                end
`endif
                default: begin
                    state <= S_UNSET;
                    out   <= 1'b1;
                    ready <= 1'b1;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_lock.sv
// Testbench for param_lock: vector table plus hand sequences, checked through
// an expected-output queue; expectations follow PARAM_LOCK_LOCKOUT_EN.
module tb_param_lock;

`ifdef PARAM_LOCK_LOCKOUT_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        in_valid;
    logic        prog;
    logic        ready;
    logic        out;
    logic        match;
    logic        fail;
    logic        alarm;
    logic [1:0]  tries_left;

    int checks = 0;
    int errs   = 0;

    logic [6:0] exp_q[$];
    string      name_q[$];

    param_lock dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .in_valid   (in_valid),
        .prog       (prog),
        .ready      (ready),
        .out        (out),
        .match      (match),
        .fail       (fail),
        .alarm      (alarm),
        .tries_left (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ex(logic o, logic r, logic m, logic f,
                                      logic a, logic [1:0] t);
        return {o, r, m, f, a, t};
    endfunction

    typedef struct {
        string       nm;
        logic        v;
        logic        p;
        logic [15:0] d;
        logic [6:0]  e;
    } vec_t;

    vec_t tbl[14];

    // Drive one cycle, queue its expectation, pop and compare after the edge.
    task automatic cyc(input string nm, input logic rst, input logic v,
                       input logic p, input logic [15:0] d,
                       input logic [6:0] e);
        logic [6:0] want;
        logic [6:0] got;
        string      n;
        reset    = rst;
        in_valid = v;
        prog     = p;
        in       = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        got  = {out, ready, match, fail, alarm, tries_left};
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got out/rdy/m/f/al/tries=%b required %b",
                     n, got, want);
        end
    endtask

    initial begin
        logic [1:0] tf;
        tf = LK ? 2'd2 : 2'd3;

        tbl[0]  = '{"unset_ignore", 1, 0, 16'd0,    ex(1,1,0,0,0,3)};
        tbl[1]  = '{"program",      1, 1, 16'd6969, ex(1,1,0,0,0,3)};
        tbl[2]  = '{"no_valid",     0, 0, 16'd6969, ex(1,1,0,0,0,3)};
        tbl[3]  = '{"wrong",        1, 0, 16'd1234, ex(1,1,0,1,0,tf)};
        tbl[4]  = '{"prog_locked",  1, 1, 16'd4242, ex(1,1,0,0,0,tf)};
        tbl[5]  = '{"unlock",       1, 0, 16'd6969, ex(0,1,1,0,0,3)};
        tbl[6]  = '{"open1",        0, 0, 16'd0,    ex(0,1,0,0,0,3)};
        tbl[7]  = '{"open2",        1, 0, 16'd6969, ex(0,1,0,0,0,3)};
        tbl[8]  = '{"open3",        0, 0, 16'd0,    ex(0,1,0,0,0,3)};
        tbl[9]  = '{"open4",        1, 0, 16'd1234, ex(0,1,0,0,0,3)};
        tbl[10] = '{"open5",        0, 0, 16'd0,    ex(0,1,0,0,0,3)};
        tbl[11] = '{"open6",        0, 0, 16'd0,    ex(0,1,0,0,0,3)};
        tbl[12] = '{"open7",        0, 0, 16'd0,    ex(0,1,0,0,0,3)};
        tbl[13] = '{"relock",       0, 0, 16'd0,    ex(1,1,0,0,0,3)};

        cyc("reset", 0, 1, 1, 16'd6969, ex(1,1,0,0,0,3));
        for (int i = 0; i < 14; i++)
            cyc(tbl[i].nm, 1, tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].e);

        // Reprogram while open
        cyc("re_unlock",  1, 1, 0, 16'd6969, ex(0,1,1,0,0,3));
        cyc("re_prog",    1, 1, 1, 16'd4242, ex(1,1,0,0,0,3));
        cyc("old_code",   1, 1, 0, 16'd6969, ex(1,1,0,1,0,tf));
        cyc("new_code",   1, 1, 0, 16'd4242, ex(0,1,1,0,0,3));
        cyc("new_open",   1, 0, 0, 16'd0,    ex(0,1,0,0,0,3));

        // Reset mid-open; the word offered with reset must be dropped
        cyc("rst_open",   0, 1, 1, 16'd1111, ex(1,1,0,0,0,3));
        cyc("rst_unset0", 1, 1, 0, 16'd0,    ex(1,1,0,0,0,3));
        cyc("rst_nocode", 1, 1, 0, 16'd1111, ex(1,1,0,0,0,3));
        cyc("reprogram",  1, 1, 1, 16'd6969, ex(1,1,0,0,0,3));

        if (LK) begin
            cyc("lk_w1", 1, 1, 0, 16'd1, ex(1,1,0,1,0,2));
            cyc("lk_w2", 1, 1, 0, 16'd2, ex(1,1,0,1,0,1));
            cyc("lk_w3", 1, 1, 0, 16'd3, ex(1,0,0,1,1,0));
            for (int i = 0; i < 15; i++)
                cyc("lk_hold", 1, 1, 0, 16'd6969, ex(1,0,0,0,1,0));
            cyc("lk_end",    1, 0, 0, 16'd0,    ex(1,1,0,0,0,3));
            cyc("lk_unlock", 1, 1, 0, 16'd6969, ex(0,1,1,0,0,3));
            for (int i = 0; i < 8; i++)
                cyc("lk_open", 1, 0, 0, 16'd0,
                    i < 7 ? ex(0,1,0,0,0,3) : ex(1,1,0,0,0,3));
            cyc("lk2_w1", 1, 1, 0, 16'd1, ex(1,1,0,1,0,2));
            cyc("lk2_w2", 1, 1, 0, 16'd2, ex(1,1,0,1,0,1));
            cyc("lk2_w3", 1, 1, 0, 16'd3, ex(1,0,0,1,1,0));
            cyc("lk2_hold", 1, 0, 0, 16'd0, ex(1,0,0,0,1,0));
            cyc("rst_lock", 0, 0, 0, 16'd0, ex(1,1,0,0,0,3));
            cyc("rst_lk_unset", 1, 1, 0, 16'd0, ex(1,1,0,0,0,3));
        end else begin
            for (int i = 0; i < 10; i++)
                cyc("unl_wrong", 1, 1, 0, 16'(i + 1), ex(1,1,0,1,0,3));
            cyc("unl_unlock", 1, 1, 0, 16'd6969, ex(0,1,1,0,0,3));
        end

        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: got %0d left required 0",
                     exp_q.size());
        end
        checks++;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
